// File: rtl/mem_cfg_pkg.sv
// mem_cfg_pkg: shared FSM states, register offsets, decode select bits and helpers
package mem_cfg_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;
  localparam int ERRCNT_OFS = 2;
  localparam int CTRL_OFS = 1;
  localparam int ID_OFS = 0;
  localparam int SEL_PORT = 3;
  localparam int SEL_ERRCNT = 2;
  localparam int SEL_CTRL = 1;
  localparam int SEL_ID = 0;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_cfg_decode.sv
// mem_cfg_decode: address decode to port index, one-hot register select, read-only and unmapped flags
module mem_cfg_decode
  import mem_cfg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NUM_PORTS = 4
) (
  input  logic [ADDR_W-1:0]             addr,
  output logic [idx_w(NUM_PORTS)-1:0]   port_idx,
  output logic [3:0]                    reg_sel,
  output logic                          is_ro,
  output logic                          is_unmapped
);
  localparam logic [ADDR_W-1:0] TOP = '1;
  assign port_idx = addr[idx_w(NUM_PORTS)-1:0];
  assign reg_sel[SEL_PORT] = addr < ADDR_W'(NUM_PORTS);
  assign reg_sel[SEL_ERRCNT] = addr == TOP - ADDR_W'(ERRCNT_OFS);
  assign reg_sel[SEL_CTRL] = addr == TOP - ADDR_W'(CTRL_OFS);
  assign reg_sel[SEL_ID] = addr == TOP - ADDR_W'(ID_OFS);
  assign is_ro = reg_sel[SEL_ERRCNT] | reg_sel[SEL_ID];
  assign is_unmapped = ~|reg_sel;
endmodule

// File: rtl/mem_cfg_regfile.sv
// mem_cfg_regfile: port address/enable register bank with wait states, error response and four-phase-safe ack
module mem_cfg_regfile
  import mem_cfg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NUM_PORTS = 4,
  parameter int WAIT_CYC = 1,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(8'hA5)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mem_sel_en,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_wr_data,
  input  logic                          mem_wr_rd_s,
  output logic [DATA_W-1:0]             mem_rd_data,
  output logic                          mem_ack,
  output logic                          mem_err,
  output logic [NUM_PORTS*DATA_W-1:0]   port_addr_o,
  output logic [NUM_PORTS-1:0]          port_en_o
);
  localparam int PW = idx_w(NUM_PORTS);
  localparam logic [3:0] LAST = WAIT_CYC == 0 ? 4'd0 : 4'(WAIT_CYC - 1);
  state_t state, state_d;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] cap_addr, acc_addr;
  logic [DATA_W-1:0] cap_wdata, acc_wdata, errcnt_q, rd_mux;
  logic cap_wr, acc_wr, go_ack, acc_err, is_ro, is_unmapped;
  logic [DATA_W-1:0] port_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] ctrl_q;
  logic [PW-1:0] port_idx;
  logic [3:0] reg_sel;
  assign acc_addr = state == IDLE ? mem_addr : cap_addr;
  assign acc_wdata = state == IDLE ? mem_wr_data : cap_wdata;
  assign acc_wr = state == IDLE ? mem_wr_rd_s : cap_wr;
  mem_cfg_decode #(.ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS)) u_decode (
    .addr        (acc_addr),
    .port_idx    (port_idx),
    .reg_sel     (reg_sel),
    .is_ro       (is_ro),
    .is_unmapped (is_unmapped)
  );
  always_comb begin
    go_ack = state == IDLE ? mem_sel_en && WAIT_CYC == 0 : state == WAIT && cnt == LAST;
    state_d = state == IDLE ? (mem_sel_en ? (WAIT_CYC == 0 ? ACK : WAIT) : IDLE) :
              state == WAIT ? (cnt == LAST ? ACK : WAIT) :
              state == ACK  ? HOLD : (mem_sel_en ? HOLD : IDLE);
    acc_err = is_unmapped | (acc_wr & is_ro & ~reg_sel[SEL_ERRCNT]);
    rd_mux = reg_sel[SEL_PORT] ? port_q[port_idx] :
             reg_sel[SEL_ERRCNT] ? errcnt_q :
             reg_sel[SEL_CTRL] ? DATA_W'(ctrl_q) :
             reg_sel[SEL_ID] ? ID_VALUE : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      cap_addr <= '0;
      cap_wdata <= '0;
      cap_wr <= 1'b0;
      ctrl_q <= '0;
      errcnt_q <= '0;
      mem_rd_data <= '0;
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) port_q[i] <= '0;
    end else begin
      mem_ack <= go_ack;
      mem_err <= go_ack & acc_err;
      cnt <= state == WAIT ? cnt + 4'd1 : '0;
      if (state == IDLE && mem_sel_en) begin
        cap_addr <= mem_addr;
        cap_wdata <= mem_wr_data;
        cap_wr <= mem_wr_rd_s;
      end
      if (go_ack && !acc_wr) mem_rd_data <= rd_mux;
      if (go_ack && acc_err && errcnt_q != '1) errcnt_q <= errcnt_q + 1'b1;
      if (go_ack && acc_wr && !acc_err) begin
        if (reg_sel[SEL_PORT]) port_q[port_idx] <= acc_wdata;
        if (reg_sel[SEL_CTRL]) ctrl_q <= acc_wdata[NUM_PORTS-1:0];
        if (reg_sel[SEL_ERRCNT]) errcnt_q <= '0;
      end
    end
  end
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign port_addr_o[i*DATA_W +: DATA_W] = port_q[i];
  end
  assign port_en_o = ctrl_q;
endmodule

// File: tb/tb_mem_cfg_regfile.sv
// tb_mem_cfg_regfile: table-driven scoreboard bench for mem_cfg_regfile across wait-state builds
module tb_mem_cfg_regfile;
  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [7:0]  rd;
    logic        err;
    logic [31:0] pa;
    logic [3:0]  pe;
    int          hold;
  } vec_t;
  typedef struct {
    logic [7:0] rd;
    logic       err;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic sel = 1'b0, wr = 1'b0;
  logic [7:0] addr = '0, wdata = '0, rd;
  logic ack, err;
  logic [31:0] pa;
  logic [3:0] pe;
  logic sel0 = 1'b0, sel15 = 1'b0;
  logic [7:0] ab = 8'hFF, wdb = 8'h00;
  logic wrb = 1'b0;
  logic ack0, ack15, err0, err15;
  logic [7:0] rd0, rd15;
  logic [31:0] pa0, pa15;
  logic [3:0] pe0, pe15;
  int checks = 0, errors = 0, ack_cnt = 0;
  logic [7:0] hold_rd = '0;
  exp_t sb[$];
  vec_t tbl[20];
  always #5 clk = ~clk;
  mem_cfg_regfile dut (
    .clk(clk), .rst_n(rst_n), .mem_sel_en(sel), .mem_addr(addr), .mem_wr_data(wdata),
    .mem_wr_rd_s(wr), .mem_rd_data(rd), .mem_ack(ack), .mem_err(err),
    .port_addr_o(pa), .port_en_o(pe)
  );
  mem_cfg_regfile #(.WAIT_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_sel_en(sel0), .mem_addr(ab), .mem_wr_data(wdb),
    .mem_wr_rd_s(wrb), .mem_rd_data(rd0), .mem_ack(ack0), .mem_err(err0),
    .port_addr_o(pa0), .port_en_o(pe0)
  );
  mem_cfg_regfile #(.WAIT_CYC(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .mem_sel_en(sel15), .mem_addr(ab), .mem_wr_data(wdb),
    .mem_wr_rd_s(wrb), .mem_rd_data(rd15), .mem_ack(ack15), .mem_err(err15),
    .port_addr_o(pa15), .port_en_o(pe15)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (ack) begin
      exp_t e;
      ack_cnt++;
      chk("ack_has_request", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rd_data", 32'(rd), 32'(e.rd));
        chk("err", 32'(err), 32'(e.err));
      end
    end
  end
  task automatic access(input vec_t v);
    int n, c0;
    exp_t e;
    e.rd = v.wr ? hold_rd : v.rd;
    e.err = v.err;
    if (!v.wr) hold_rd = v.rd;
    sb.push_back(e);
    c0 = ack_cnt;
    @(negedge clk);
    wr = v.wr; addr = v.a; wdata = v.d; sel = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 40);
    chk($sformatf("latency_%h", v.a), 32'(n), 32'd2);
    chk($sformatf("port_addr_%h", v.a), pa, v.pa);
    chk($sformatf("port_en_%h", v.a), 32'(pe), 32'(v.pe));
    repeat (v.hold) @(posedge clk);
    #1 sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("ack_count", 32'(ack_cnt - c0), 32'd1);
  endtask
  task automatic lat(input bit w15, input int drop, input int exp);
    int n;
    bit got;
    @(negedge clk);
    if (w15) sel15 = 1'b1; else sel0 = 1'b1;
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk); #1; n++;
      if (n == drop) begin sel0 = 1'b0; sel15 = 1'b0; end
      got = w15 ? ack15 : ack0;
    end
    chk(w15 ? "lat15" : "lat0", 32'(n), 32'(exp));
    chk(w15 ? "lat15_rd" : "lat0_rd", 32'(w15 ? rd15 : rd0), 32'h0000_00A5);
    chk(w15 ? "lat15_err" : "lat0_err", 32'(w15 ? err15 : err0), 32'd0);
    sel0 = 1'b0; sel15 = 1'b0;
    repeat (2) @(posedge clk);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 8'h02, 8'h3C, 8'h00, 1'b0, 32'h003C0000, 4'h0, 3};
    tbl[1]  = '{1'b0, 8'h02, 8'h00, 8'h3C, 1'b0, 32'h003C0000, 4'h0, 0};
    tbl[2]  = '{1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0, 32'h003C0000, 4'h0, 0};
    tbl[3]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 32'h003C0000, 4'h0, 0};
    tbl[4]  = '{1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0, 32'h003C0000, 4'h0, 0};
    tbl[5]  = '{1'b0, 8'hFD, 8'h00, 8'h01, 1'b0, 32'h003C0000, 4'h0, 0};
    tbl[6]  = '{1'b1, 8'hFE, 8'hFF, 8'h00, 1'b0, 32'h003C0000, 4'hF, 0};
    tbl[7]  = '{1'b0, 8'hFE, 8'h00, 8'h0F, 1'b0, 32'h003C0000, 4'hF, 0};
    tbl[8]  = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 32'h003C0000, 4'hF, 0};
    tbl[9]  = '{1'b0, 8'hFD, 8'h00, 8'h02, 1'b0, 32'h003C0000, 4'hF, 0};
    tbl[10] = '{1'b1, 8'hFD, 8'h55, 8'h00, 1'b0, 32'h003C0000, 4'hF, 1};
    tbl[11] = '{1'b0, 8'hFD, 8'h00, 8'h00, 1'b0, 32'h003C0000, 4'hF, 0};
    tbl[12] = '{1'b1, 8'h40, 8'h77, 8'h00, 1'b1, 32'h003C0000, 4'hF, 0};
    tbl[13] = '{1'b0, 8'hFD, 8'h00, 8'h01, 1'b0, 32'h003C0000, 4'hF, 0};
    tbl[14] = '{1'b1, 8'h00, 8'h11, 8'h00, 1'b0, 32'h003C0011, 4'hF, 0};
    tbl[15] = '{1'b1, 8'h01, 8'h22, 8'h00, 1'b0, 32'h003C2211, 4'hF, 0};
    tbl[16] = '{1'b1, 8'h03, 8'h44, 8'h00, 1'b0, 32'h443C2211, 4'hF, 2};
    tbl[17] = '{1'b0, 8'h03, 8'h00, 8'h44, 1'b0, 32'h443C2211, 4'hF, 0};
    tbl[18] = '{1'b1, 8'h04, 8'h99, 8'h00, 1'b1, 32'h443C2211, 4'hF, 0};
    tbl[19] = '{1'b0, 8'hFD, 8'h00, 8'h02, 1'b0, 32'h443C2211, 4'hF, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_pa", pa, 32'd0);
    chk("rst_pe", 32'(pe), 32'd0);
    chk("rst_ack15", 32'(ack15), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) access(tbl[i]);
    lat(1'b0, 0, 1);
    lat(1'b1, 0, 16);
    lat(1'b1, 3, 16);
    lat(1'b1, 0, 16);
    lat(1'b0, 0, 1);
    @(negedge clk);
    wr = 1'b1; addr = 8'h00; wdata = 8'hAB; sel = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0; sel = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold_rd = 8'h00;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_rd", 32'(rd), 32'd0);
    chk("midrst_pa", pa, 32'd0);
    chk("midrst_pe", 32'(pe), 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("midrst_no_ack", 32'(ack_cnt), 32'(ack_cnt - int'(sb.size() != 0)));
    access('{1'b1, 8'h00, 8'h5A, 8'h00, 1'b0, 32'h0000005A, 4'h0, 0});
    access('{1'b0, 8'hFD, 8'h00, 8'h00, 1'b0, 32'h0000005A, 4'h0, 0});
    for (int i = 0; i < 300; i++)
      access('{1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 32'h0000005A, 4'h0, 0});
    access('{1'b0, 8'hFD, 8'h00, 8'hFF, 1'b0, 32'h0000005A, 4'h0, 0});
    access('{1'b1, 8'hFF, 8'h12, 8'h00, 1'b1, 32'h0000005A, 4'h0, 0});
    access('{1'b0, 8'hFD, 8'h00, 8'hFF, 1'b0, 32'h0000005A, 4'h0, 0});
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
